// File: rtl/serial_compare_ctrl.sv
// ---------------------------------------------------------------------------
// serial_compare_ctrl
//  Sequencer that time-shares one external 2-bit cascadable comparator slice
//  to compare two WIDTH-bit unsigned operands, MSB pair first. Operands are
//  latched on an accepted start. One bit pair is presented per cycle, and the
//  slice EQ/GT outputs are fed back as the next cascade inputs. The final
//  result is reported as registered eq/gt/lt together with a one-cycle done.
//
//  Parameters
//   WIDTH         operand width in bits (even, >= 2); N = WIDTH/2 slice pairs
//
//  Ports
//   clk, rst_n    rising-edge clock, asynchronous active-low reset
//   start         request, accepted only while ready=1
//   a_in, b_in    operands, sampled with an accepted start
//   ready         1 in IDLE (combinational from state)
//   slice_a/b     bit pair of the latched operands driven to the slice
//   slice_eq_in   cascade eq input to the slice
//   slice_gt_in   cascade gt input to the slice
//   slice_eq_out  slice EQ result
//   slice_gt_out  slice GT result
//   done          one-cycle pulse, result valid
//   eq/gt/lt      registered one-hot result, held until the next done
//
//  Build option
//   SERIAL_CMP_EARLY_EXIT_EN  when defined, RUN ends at the first differing
//                             pair instead of always scanning all N pairs.
// ---------------------------------------------------------------------------
module serial_compare_ctrl #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a_in,
   input  logic [WIDTH-1:0] b_in,
   output logic             ready,
   output logic [1:0]       slice_a,
   output logic [1:0]       slice_b,
   output logic             slice_eq_in,
   output logic             slice_gt_in,
   input  logic             slice_eq_out,
   input  logic             slice_gt_out,
   output logic             done,
   output logic             eq,
   output logic             gt,
   output logic             lt
);

   localparam int unsigned N     = WIDTH / 2;
   localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t             r_state;
   state_t             w_state_nxt;
   logic [WIDTH-1:0]   r_a;
   logic [WIDTH-1:0]   r_b;
   logic [IDX_W-1:0]   r_idx;
   logic               r_eq;
   logic               r_gt;
   logic               r_done;
   logic               r_res_eq;
   logic               r_res_gt;
   logic               r_res_lt;
   logic               w_accept;
   logic               w_run;
   logic               w_last;
   logic               w_early;
   logic [1:0]         w_pair_a;
   logic [1:0]         w_pair_b;

   // Early exit: a differing pair already decides the result.
`ifdef SERIAL_CMP_EARLY_EXIT_EN
   assign w_early = ~slice_eq_out;
`else
   assign w_early = 1'b0;
`endif

   assign w_run = (r_state == S_RUN);

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state logic and per-cycle control strobes
   always_comb begin
      w_state_nxt = r_state;
      w_accept    = 1'b0;
      w_last      = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (start) begin
               w_accept    = 1'b1;
               w_state_nxt = S_RUN;
            end
         end
         S_RUN: begin
            w_last = (r_idx == '0) | w_early;
            if (w_last) begin
               w_state_nxt = S_DONE;
            end
         end
         S_DONE: begin
            w_state_nxt = S_IDLE;
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // Select the current bit pair from the latched operands
   always_comb begin
      w_pair_a = 2'b00;
      w_pair_b = 2'b00;
      for (int i = 0; i < int'(N); i++) begin
         if (r_idx == IDX_W'(i)) begin
            w_pair_a = r_a[2*i +: 2];
            w_pair_b = r_b[2*i +: 2];
         end
      end
   end

   // Operand latch, pair index, cascade accumulators and result registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_a      <= '0;
         r_b      <= '0;
         r_idx    <= '0;
         r_eq     <= 1'b1;
         r_gt     <= 1'b0;
         r_done   <= 1'b0;
         r_res_eq <= 1'b0;
         r_res_gt <= 1'b0;
         r_res_lt <= 1'b0;
      end else begin
         r_done <= 1'b0;
         if (w_accept) begin
            r_a   <= a_in;
            r_b   <= b_in;
            r_idx <= IDX_W'(N - 1);
            r_eq  <= 1'b1;
            r_gt  <= 1'b0;
         end else if (w_run) begin
            r_eq <= slice_eq_out;
            r_gt <= slice_gt_out;
            if (w_last) begin
               // Result captured on the same edge as the final cascade step
               r_done   <= 1'b1;
               r_res_eq <= slice_eq_out;
               r_res_gt <= slice_gt_out;
               r_res_lt <= ~slice_eq_out & ~slice_gt_out;
            end else begin
               r_idx <= r_idx - IDX_W'(1);
            end
         end
      end
   end

   // Slice drive: idle values keep the slice in a neutral cascade state
   assign slice_a     = w_run ? w_pair_a : 2'b00;
   assign slice_b     = w_run ? w_pair_b : 2'b00;
   assign slice_eq_in = w_run ? r_eq : 1'b1;
   assign slice_gt_in = w_run ? r_gt : 1'b0;

   assign ready = (r_state == S_IDLE);
   assign done  = r_done;
   assign eq    = r_res_eq;
   assign gt    = r_res_gt;
   assign lt    = r_res_lt;

endmodule
